// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter slice.
//   arb_state_t       : arbiter FSM state encoding
//   arb_gnt_t         : grant identifiers (fetch / load-store)
//   ARB_TO_CYCLES_DEF : default memory-ack timeout in cycles
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } arb_gnt_t;

  localparam int unsigned ARB_TO_CYCLES_DEF = 16;

endpackage

// File: rtl/arb_timer.sv
// Timeout counter for the arbiter.
//   a_clk  : clock
//   a_rst  : asynchronous active-low reset
//   clr    : clear the count (held while no transaction is in flight)
//   inc    : count one busy cycle
//   expire : high in the busy cycle in which the count reaches TO_CYCLES
module arb_timer
  import arb_pkg::*;
#(
  parameter int unsigned TO_CYCLES = ARB_TO_CYCLES_DEF
) (
  input  logic a_clk,
  input  logic a_rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [7:0] cnt_q;

  // cnt_q holds the number of completed busy cycles; the edge that would
  // make it equal TO_CYCLES is the one that ends the transaction.
  assign expire = inc && (cnt_q == 8'(TO_CYCLES - 1));

  always_ff @(posedge a_clk or negedge a_rst) begin
    if (!a_rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !expire) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load-store port onto one shared memory port.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests;
// when undefined, load-store has fixed priority.
//   a_clk, a_rst                         : clock, async active-low reset
//   a_f_syn/a_f_addr -> a_f_ack/a_f_rdata : fetch request / completion
//   a_d_syn/a_d_we/a_d_addr/a_d_wdata
//     -> a_d_ack/a_d_rdata                : load-store request / completion
//   a_m_syn/a_m_we/a_m_addr/a_m_wdata     : shared memory request
//   a_m_ack/a_m_rdata                     : memory completion
//   a_o_stall                             : fetch waiting on a load-store
//   a_o_err                               : one-cycle pulse on memory timeout
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned TO_CYCLES = ARB_TO_CYCLES_DEF
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic              a_f_syn,
  input  logic [AWIDTH-1:0] a_f_addr,
  output logic              a_f_ack,
  output logic [DWIDTH-1:0] a_f_rdata,
  input  logic              a_d_syn,
  input  logic              a_d_we,
  input  logic [AWIDTH-1:0] a_d_addr,
  input  logic [DWIDTH-1:0] a_d_wdata,
  output logic              a_d_ack,
  output logic [DWIDTH-1:0] a_d_rdata,
  output logic              a_m_syn,
  output logic              a_m_we,
  output logic [AWIDTH-1:0] a_m_addr,
  output logic [DWIDTH-1:0] a_m_wdata,
  input  logic              a_m_ack,
  input  logic [DWIDTH-1:0] a_m_rdata,
  output logic              a_o_stall,
  output logic              a_o_err
);

  arb_state_t        state_q, state_d;
  arb_gnt_t          owner_q, win;
  logic              busy, any_req, grant, finish, expire;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;

  assign busy    = (state_q == BUSY_F) || (state_q == BUSY_D);
  assign any_req = a_f_syn || a_d_syn;
  assign grant   = (state_q == IDLE) && any_req;
  assign finish  = busy && (a_m_ack || expire);

`ifdef ARB_ROUND_ROBIN_EN
  arb_gnt_t last_q;

  always_comb begin
    win = a_d_syn ? GNT_DATA : GNT_FETCH;
    if (a_f_syn && a_d_syn) begin
      win = (last_q == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end
  end

  always_ff @(posedge a_clk or negedge a_rst) begin
    if (!a_rst) begin
      last_q <= GNT_FETCH;
    end else if (grant) begin
      last_q <= win;
    end
  end
`else
  always_comb begin
    win = a_d_syn ? GNT_DATA : GNT_FETCH;
  end
`endif

  arb_timer #(
    .TO_CYCLES (TO_CYCLES)
  ) u_timer (
    .a_clk  (a_clk),
    .a_rst  (a_rst),
    .clr    (!busy),
    .inc    (busy),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (any_req) state_d = (win == GNT_DATA) ? BUSY_D : BUSY_F;
      BUSY_F, BUSY_D: if (a_m_ack || expire) state_d = DONE;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q   <= IDLE;
      owner_q   <= GNT_FETCH;
      a_m_we    <= 1'b0;
      a_m_addr  <= '0;
      a_m_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (grant) begin
        owner_q <= win;
        if (win == GNT_DATA) begin
          a_m_we    <= a_d_we;
          a_m_addr  <= a_d_addr;
          a_m_wdata <= a_d_wdata;
        end else begin
          a_m_we    <= 1'b0;
          a_m_addr  <= a_f_addr;
          a_m_wdata <= '0;
        end
      end
      // An ack in the expiring cycle wins over the timeout.
      if (finish) begin
        rdata_q <= a_m_ack ? a_m_rdata : '0;
        err_q   <= !a_m_ack;
      end
    end
  end

  assign a_m_syn   = busy;
  assign a_f_ack   = (state_q == DONE) && (owner_q == GNT_FETCH);
  assign a_d_ack   = (state_q == DONE) && (owner_q == GNT_DATA);
  assign a_f_rdata = a_f_ack ? rdata_q : '0;
  assign a_d_rdata = a_d_ack ? rdata_q : '0;
  assign a_o_stall = a_f_syn && (state_q == BUSY_D);
  assign a_o_err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TO_CYCLES = 4).
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_syn;
  logic [AW-1:0] f_addr;
  logic          f_ack;
  logic [DW-1:0] f_rdata;
  logic          d_syn, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_syn, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;
  logic          stall, err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AWIDTH    (AW),
    .DWIDTH    (DW),
    .TO_CYCLES (4)
  ) dut (
    .a_clk     (clk),
    .a_rst     (rst),
    .a_f_syn   (f_syn),
    .a_f_addr  (f_addr),
    .a_f_ack   (f_ack),
    .a_f_rdata (f_rdata),
    .a_d_syn   (d_syn),
    .a_d_we    (d_we),
    .a_d_addr  (d_addr),
    .a_d_wdata (d_wdata),
    .a_d_ack   (d_ack),
    .a_d_rdata (d_rdata),
    .a_m_syn   (m_syn),
    .a_m_we    (m_we),
    .a_m_addr  (m_addr),
    .a_m_wdata (m_wdata),
    .a_m_ack   (m_ack),
    .a_m_rdata (m_rdata),
    .a_o_stall (stall),
    .a_o_err   (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; f_syn = 1'b0; f_addr = '0; d_syn = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
    #1;
    chk("rst_m_syn",  64'(m_syn),  64'h0);
    chk("rst_m_addr", 64'(m_addr), 64'h0);
    chk("rst_f_ack",  64'(f_ack),  64'h0);
    chk("rst_d_ack",  64'(d_ack),  64'h0);
    chk("rst_err",    64'(err),    64'h0);
    chk("rst_stall",  64'(stall),  64'h0);
    tick(); tick();
    rst = 1'b1;

    // Fetch-only transaction, memory acks in the second busy cycle.
    tick();
    f_syn = 1'b1; f_addr = 32'h100;
    tick();
    chk("f1_m_syn",   64'(m_syn),   64'h1);
    chk("f1_m_addr",  64'(m_addr),  64'h100);
    chk("f1_m_we",    64'(m_we),    64'h0);
    chk("f1_m_wdata", 64'(m_wdata), 64'h0);
    chk("f1_f_ack0",  64'(f_ack),   64'h0);
    tick();
    chk("f1_m_syn2",  64'(m_syn),   64'h1);
    m_ack = 1'b1; m_rdata = 32'hA0A0A0A0;
    tick();
    chk("f1_f_ack",   64'(f_ack),   64'h1);
    chk("f1_f_rdata", 64'(f_rdata), 64'hA0A0A0A0);
    chk("f1_m_syn_d", 64'(m_syn),   64'h0);
    chk("f1_err",     64'(err),     64'h0);
    chk("f1_d_ack",   64'(d_ack),   64'h0);
    m_ack = 1'b0; m_rdata = '0;
    // Requester keeps syn up across the DONE edge; must not be re-granted.
    tick();
    chk("f1_ack_one", 64'(f_ack),   64'h0);
    chk("f1_idle",    64'(m_syn),   64'h0);
    f_syn = 1'b0;
    tick();
    chk("f1_no_regr", 64'(m_syn),   64'h0);

    // Stray memory ack while idle is ignored.
    m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    tick();
    chk("stray_f_ack", 64'(f_ack), 64'h0);
    chk("stray_d_ack", 64'(d_ack), 64'h0);
    chk("stray_m_syn", 64'(m_syn), 64'h0);
    m_ack = 1'b0; m_rdata = '0;

    // Simultaneous fetch and store: store first, fetch stalled.
    f_syn = 1'b1; f_addr = 32'h200;
    d_syn = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55;
    tick();
    chk("p_m_addr",  64'(m_addr),  64'h40);
    chk("p_m_we",    64'(m_we),    64'h1);
    chk("p_m_wdata", 64'(m_wdata), 64'h55);
    chk("p_stall",   64'(stall),   64'h1);
    m_ack = 1'b1; m_rdata = 32'h12345678;
    tick();
    chk("p_d_ack",   64'(d_ack),   64'h1);
    chk("p_d_rdata", 64'(d_rdata), 64'h12345678);
    chk("p_f_ack0",  64'(f_ack),   64'h0);
    chk("p_stall0",  64'(stall),   64'h0);
    m_ack = 1'b0; m_rdata = '0; d_syn = 1'b0; d_we = 1'b0;
    tick();
    chk("p_gap",     64'(m_syn),   64'h0);
    tick();
    chk("p2_m_syn",  64'(m_syn),   64'h1);
    chk("p2_m_addr", 64'(m_addr),  64'h200);
    chk("p2_m_we",   64'(m_we),    64'h0);
    chk("p2_m_wd",   64'(m_wdata), 64'h0);
    m_ack = 1'b1; m_rdata = 32'h11112222;
    tick();
    chk("p2_f_ack",  64'(f_ack),   64'h1);
    chk("p2_f_rd",   64'(f_rdata), 64'h11112222);
    m_ack = 1'b0; m_rdata = '0; f_syn = 1'b0;
    tick();

    // Timeout: no memory ack for 4 busy cycles.
    f_syn = 1'b1; f_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_busy", 64'(m_syn), 64'h1);
      chk("to_noack", 64'(f_ack), 64'h0);
    end
    tick();
    chk("to_f_ack",  64'(f_ack),   64'h1);
    chk("to_f_rd",   64'(f_rdata), 64'h0);
    chk("to_err",    64'(err),     64'h1);
    chk("to_m_syn",  64'(m_syn),   64'h0);
    f_syn = 1'b0;
    tick();
    chk("to_err_1c", 64'(err),     64'h0);
    chk("to_ack_1c", 64'(f_ack),   64'h0);

    // Ack arriving in the expiring cycle counts as success.
    f_syn = 1'b1; f_addr = 32'h304;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bd_busy", 64'(m_syn), 64'h1);
    end
    m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    tick();
    chk("bd_f_ack", 64'(f_ack),   64'h1);
    chk("bd_f_rd",  64'(f_rdata), 64'hCAFEF00D);
    chk("bd_err",   64'(err),     64'h0);
    m_ack = 1'b0; m_rdata = '0; f_syn = 1'b0;
    tick();

    // Reset during BUSY_D.
    d_syn = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = '0;
    tick();
    chk("rs_busy",  64'(m_syn), 64'h1);
    chk("rs_stall", 64'(stall), 64'h0);
    #2 rst = 1'b0;
    #1;
    chk("rs_m_syn", 64'(m_syn),  64'h0);
    chk("rs_m_adr", 64'(m_addr), 64'h0);
    chk("rs_d_ack", 64'(d_ack),  64'h0);
    tick();
    chk("rs_d_ack2", 64'(d_ack), 64'h0);
    chk("rs_err",    64'(err),   64'h0);
    rst = 1'b1;
    tick();
    chk("rs_regrant", 64'(m_syn),  64'h1);
    chk("rs_addr",    64'(m_addr), 64'h80);
    m_ack = 1'b1; m_rdata = 32'h0BADF00D;
    tick();
    chk("rs_ack",   64'(d_ack),   64'h1);
    chk("rs_rdata", 64'(d_rdata), 64'h0BADF00D);
    m_ack = 1'b0; m_rdata = '0;
    // Last grant was load-store: a new simultaneous pair goes to fetch
    // under round-robin, to load-store under fixed priority.
    f_syn = 1'b1; f_addr = 32'h500;
    d_syn = 1'b1; d_addr = 32'h600;
    tick();
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("arb_addr", 64'(m_addr), 64'h500);
`else
    chk("arb_addr", 64'(m_addr), 64'h600);
`endif
    m_ack = 1'b1; m_rdata = 32'h77;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("arb_ack", 64'(f_ack), 64'h1);
`else
    chk("arb_ack", 64'(d_ack), 64'h1);
`endif
    m_ack = 1'b0; m_rdata = '0; f_syn = 1'b0; d_syn = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
